// File: rtl/mul_issue_unit.sv
// mul_issue_unit: issue stage between execute and the iterative multiplier.
// Holds one RV32M multiply op, issues it, captures the result and presents
// it to writeback tagged with rd. Flushes never abort an in-flight multiply;
// an outstanding result is drained and discarded instead.
// Optional feature: define MUL_ISSUE_CACHE_EN for a one-entry result cache.
module mul_issue_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [RD_W-1:0] in_rd,
  output logic            mul_valid,
  input  logic            mul_ready,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  output logic [1:0]      mul_op,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [XLEN-1:0] res_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } riscv_mul_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [RD_W-1:0] rd_q, rd_d;
  riscv_mul_op_e op_q, op_d, op_dec;
  logic          err_q, err_d;
  logic          accept;

`ifdef MUL_ISSUE_CACHE_EN
  logic            c_vld_q, c_vld_d;
  logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_res_q, c_res_d;
  riscv_mul_op_e   c_op_q, c_op_d;
  logic            c_hit;
`endif

  // Flush blocks acceptance in the same cycle, so it gates in_ready directly
  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign mul_valid = (state_q == S_ISSUE);
  assign res_ready = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign wb_valid  = (state_q == S_WB);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign mul_op    = op_q;
  assign wb_rd     = rd_q;
  assign wb_data   = data_q;
  assign wb_err    = err_q;

  assign accept = in_valid && in_ready;
  assign op_dec = riscv_mul_op_e'(in_funct3[1:0]);

`ifdef MUL_ISSUE_CACHE_EN
  assign c_hit = c_vld_q && (c_a_q == in_rs1) && (c_b_q == in_rs2) && (c_op_q == op_dec);
`endif

  // Next-state and held-register update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef MUL_ISSUE_CACHE_EN
    c_vld_d = c_vld_q;
    c_a_d   = c_a_q;
    c_b_d   = c_b_q;
    c_op_d  = c_op_q;
    c_res_d = c_res_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d    = in_rs1;
          b_d    = in_rs2;
          op_d   = op_dec;
          rd_d   = in_rd;
          data_d = '0;
          err_d  = 1'b0;
          if (in_funct3[2]) begin
            err_d   = 1'b1;
            state_d = S_WB;
          end else if (in_rd == '0) begin
            state_d = S_WB;
`ifdef MUL_ISSUE_CACHE_EN
          end else if (c_hit) begin
            data_d  = c_res_q;
            state_d = S_WB;
`endif
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (flush)          state_d = S_IDLE;
        else if (mul_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result consumed in the flush cycle needs no drain
        if (flush) begin
          state_d = res_valid ? S_IDLE : S_DRAIN;
        end else if (res_valid) begin
          data_d  = res_data;
          err_d   = 1'b0;
          state_d = S_WB;
`ifdef MUL_ISSUE_CACHE_EN
          c_vld_d = 1'b1;
          c_a_d   = a_q;
          c_b_d   = b_q;
          c_op_d  = op_q;
          c_res_d = res_data;
`endif
        end
      end
      S_WB: begin
        if (flush || wb_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (res_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef MUL_ISSUE_CACHE_EN
    if (flush) c_vld_d = 1'b0;
`endif
  end

  // State and held registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

`ifdef MUL_ISSUE_CACHE_EN
  // One-entry result cache
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_vld_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_op_q  <= OP_MUL;
      c_res_q <= '0;
    end else begin
      c_vld_q <= c_vld_d;
      c_a_q   <= c_a_d;
      c_b_q   <= c_b_d;
      c_op_q  <= c_op_d;
      c_res_q <= c_res_d;
    end
  end
`endif

endmodule

// File: tb/tb_mul_issue_unit.sv
// tb_mul_issue_unit: directed scoreboard bench for mul_issue_unit with a
// behavioural multiplier. Honors MUL_ISSUE_CACHE_EN for the cache case.
module tb_mul_issue_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        mul_valid, mul_ready;
  logic [31:0] mul_a, mul_b;
  logic [1:0]  mul_op;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        wb_valid, wb_ready, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mul_issue_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_rd(in_rd),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_op(mul_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   mul_valid_cycles = 0;
  int   wb_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [63:0] xa, xb, p;
    xa = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    xb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = xa * xb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Behavioural multiplier: 1-cycle request handshake, 3-cycle latency
  initial begin : mul_model
    logic [31:0] pend;
    logic        got;
    int          n;
    mul_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && mul_valid) begin
        mul_ready = 1'b1;
        pend = ref_mul(mul_a, mul_b, mul_op);
        @(posedge clk); #1;
        mul_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        res_valid = 1'b1;
        res_data  = pend;
        n = 0;
        do begin
          @(negedge clk);
          got = res_ready;
          @(posedge clk);
          n++;
        end while (!got && n < 200);
        if (!got) begin
          total++; bad++;
          $display("FAIL res_handshake: got res_ready=0 want 1 within 200 cycles");
        end
        #1 res_valid = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every writeback handshake
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && mul_valid) mul_valid_cycles++;
      if (!rst && wb_valid && wb_ready) begin
        wb_count++;
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_unexpected: got rd=%0d data=0x%08h want no writeback", wb_rd, wb_data);
        end else begin
          e = sbq.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
          chk("wb_err", 32'(wb_err), 32'(e.err));
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] d, input logic err,
                      input bit push, input bit fast);
    exp_t x;
    int   n;
    if (push) begin
      x.rd = rd; x.data = d; x.err = err;
      sbq.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_rs1 = a; in_rs2 = b; in_funct3 = f3; in_rd = rd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (fast) begin
      @(negedge clk);
      chk("one_cycle_latency", 32'(wb_valid), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL idle_timeout: got in_ready=0 want 1 within 300 cycles");
    end
  endtask

  task automatic wait_wb();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_valid && n < 200);
    if (!wb_valid) begin
      total++; bad++;
      $display("FAIL wb_timeout: got wb_valid=0 want 1 within 200 cycles");
    end
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got no finish want finish by 200us");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int mvc0, wbc0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
    in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mul_valid", 32'(mul_valid), 32'd0);
    chk("rst_res_ready", 32'(res_ready), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic multiplies through the multiplier
    send(32'd7, 32'hFFFF_FFFD, 3'b000, 5'd5, 32'hFFFF_FFEB, 1'b0, 1, 0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 5'd6, 32'hFFFF_FFFE, 1'b0, 1, 0);
    send(32'hFFFF_FFFF, 32'd2, 3'b010, 5'd7, 32'hFFFF_FFFF, 1'b0, 1, 0);
    send(32'h0001_0000, 32'h0001_0000, 3'b000, 5'd8, 32'h0000_0000, 1'b0, 1, 0);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'b001, 5'd9, 32'h3FFF_FFFF, 1'b0, 1, 0);
    wait_idle();

    // Writeback backpressure: outputs hold, nothing accepted
    wb_ready = 1'b0;
    send(32'h1234_5678, 32'd1, 3'b000, 5'd10, 32'h1234_5678, 1'b0, 1, 0);
    wait_wb();
    repeat (10) begin
      @(negedge clk);
      chk("stall_wb_valid", 32'(wb_valid), 32'd1);
      chk("stall_wb_data", wb_data, 32'h1234_5678);
      chk("stall_wb_rd", 32'(wb_rd), 32'd10);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    wait_idle();

    // Flush while waiting for the result: result drained, no writeback
    wbc0 = wb_count;
    send(32'd5, 32'd6, 3'b000, 5'd11, 32'd30, 1'b0, 0, 0);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!res_ready && n < 100);
      chk("reach_wait", 32'(res_ready), 32'd1);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (10) @(negedge clk);
    chk("drain_res_consumed", 32'(res_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    chk("drain_no_wb", 32'(wb_count), 32'(wbc0));
    send(32'd3, 32'd4, 3'b000, 5'd12, 32'h0000_000C, 1'b0, 1, 0);
    wait_idle();

    // Flush in writeback: wb_valid drops next cycle
    wb_ready = 1'b0;
    send(32'd2, 32'd5, 3'b000, 5'd13, 32'd10, 1'b0, 0, 0);
    wait_wb();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("wb_flush_valid", 32'(wb_valid), 32'd0);
    chk("wb_flush_in_ready", 32'(in_ready), 32'd1);
    wb_ready = 1'b1;

    // Flush in idle blocks acceptance
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_rs1 = 32'd9; in_rs2 = 32'd9; in_funct3 = 3'b000; in_rd = 5'd14;
    @(negedge clk);
    chk("idle_flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("idle_flush_no_issue", 32'(mul_valid), 32'd0);
    chk("idle_flush_no_wb", 32'(wb_valid), 32'd0);

    // rd=0 and non-multiply funct3 bypass the multiplier
    wait_idle();
    mvc0 = mul_valid_cycles;
    send(32'd7, 32'd8, 3'b000, 5'd0, 32'd0, 1'b0, 1, 1);
    send(32'd7, 32'd8, 3'b100, 5'd15, 32'd0, 1'b1, 1, 1);
    wait_idle();
    chk("bypass_no_mul_valid", 32'(mul_valid_cycles), 32'(mvc0));

    // Repeated MULH: second one served from cache when enabled
    send(32'h8000_0000, 32'h8000_0000, 3'b001, 5'd16, 32'h4000_0000, 1'b0, 1, 0);
    wait_idle();
`ifdef MUL_ISSUE_CACHE_EN
    mvc0 = mul_valid_cycles;
    send(32'h8000_0000, 32'h8000_0000, 3'b001, 5'd17, 32'h4000_0000, 1'b0, 1, 1);
    wait_idle();
    chk("cache_no_mul_valid", 32'(mul_valid_cycles), 32'(mvc0));
`else
    send(32'h8000_0000, 32'h8000_0000, 3'b001, 5'd17, 32'h4000_0000, 1'b0, 1, 0);
    wait_idle();
`endif

    begin
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
